// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline-control / hazard block.
package pipe_pkg;

    // Forward select value meaning "take the operand from the register file"
    localparam int FWD_RF      = 0;

    // Default geometry of the post-decode pipe
    localparam int STAGES_DEF  = 3;
    localparam int CTRLW_DEF   = 16;
    localparam int REGS_DEF    = 16;

    // Width of the saturating stall counter
    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_entry.sv
// One post-decode stage register: takes the upstream entry or a bubble (all zeros).
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         take,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    // Capture the upstream entry, or insert a bubble; reset clears the whole entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout <= '0;
        end else begin
            dout <= take ? din : '0;
        end
    end

endmodule

// File: rtl/pipe_hazard.sv
// Generic post-decode control chain with load-use stall, branch flush,
// operand-forward selection and a saturating stall counter.
module pipe_hazard
    import pipe_pkg::*;
#(
    parameter int STAGES = STAGES_DEF,
    parameter int REGS   = REGS_DEF,
    parameter int CTRLW  = CTRLW_DEF,
    parameter int RAW    = $clog2(REGS),
    parameter int FWW    = $clog2(STAGES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      d_valid,
    input  logic [CTRLW-1:0]          d_ctrl,
    input  logic [RAW-1:0]            d_rd,
    input  logic                      d_we,
    input  logic                      d_load,
    input  logic [RAW-1:0]            d_ra1,
    input  logic [RAW-1:0]            d_ra2,
    input  logic                      d_use1,
    input  logic                      d_use2,
    input  logic                      branch_taken,
    output logic                      stall_d,
    output logic                      flush_d,
    output logic [FWW-1:0]            fwd_a,
    output logic [FWW-1:0]            fwd_b,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES*CTRLW-1:0]   stage_ctrl,
    output logic [STALL_CNT_W-1:0]    stall_cnt
);

    // Entry layout, MSB to LSB: valid, ctrl, rd, we, load, ra1, ra2, use1, use2
    localparam int LOW_W = 2*RAW + 3;
    localparam int ENTW  = CTRLW + RAW + 2 + LOW_W;

    logic [ENTW-1:0]  entD [STAGES];
    logic [ENTW-1:0]  entQ [STAGES];

    logic [STAGES-1:0] stValid;
    logic [STAGES-1:0] stWe;
    logic [CTRLW-1:0]  stCtrl [STAGES];
    logic [RAW-1:0]    stRd   [STAGES];

    logic              headLoad;
    logic [RAW-1:0]    headRa1;
    logic [RAW-1:0]    headRa2;
    logic              headUse1;
    logic              headUse2;

    logic              headHazard;
    logic              accept;
    logic [STALL_CNT_W-1:0] stallCnt;
    logic              unusedTail;

    function automatic logic [STALL_CNT_W-1:0] satInc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + STALL_CNT_W'(1);
    endfunction

    assign entD[0] = {d_valid, d_ctrl, d_rd, d_we, d_load, d_ra1, d_ra2, d_use1, d_use2};

    for (genvar gi = 0; gi < STAGES; gi++) begin : gStage
        if (gi > 0) begin : gChain
            assign entD[gi] = entQ[gi-1];
        end

        pipe_entry #(.W(ENTW)) uEntry (
            .clk   (clk),
            .reset (reset),
            .take  ((gi == 0) ? accept : 1'b1),
            .din   (entD[gi]),
            .dout  (entQ[gi])
        );

        assign {stValid[gi], stCtrl[gi], stRd[gi], stWe[gi]} = entQ[gi][ENTW-1:LOW_W];
        assign stage_ctrl[gi*CTRLW +: CTRLW] = stCtrl[gi];
    end

    // Source-operand fields are only needed for the stage-0 instruction
    assign {headLoad, headRa1, headRa2, headUse1, headUse2} = entQ[0][LOW_W-1:0];
    assign unusedTail = ^entQ[STAGES-1][LOW_W-1:0];

    assign stage_valid = stValid;

    // Load in stage 0 whose result the decode instruction needs next cycle
    assign headHazard = stValid[0] & stWe[0] & headLoad &
                        (((stRd[0] == d_ra1) & d_use1) | ((stRd[0] == d_ra2) & d_use2));

    // A taken branch discards decode, which also cancels any stall it would have caused
    assign flush_d = branch_taken & stValid[0];
    assign stall_d = d_valid & headHazard & ~flush_d;
    assign accept  = d_valid & ~stall_d & ~flush_d;

    // Youngest matching producer wins: scan oldest to youngest, last hit overrides
    always_comb begin
        fwd_a = FWW'(FWD_RF);
        fwd_b = FWW'(FWD_RF);
        for (int k = STAGES-1; k >= 1; k--) begin
            if (stValid[k] && stWe[k] && stValid[0] && headUse1 && (stRd[k] == headRa1)) begin
                fwd_a = FWW'(k);
            end
            if (stValid[k] && stWe[k] && stValid[0] && headUse2 && (stRd[k] == headRa2)) begin
                fwd_b = FWW'(k);
            end
        end
    end

    // Saturating count of cycles in which decode is held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCnt <= '0;
        end else if (stall_d) begin
            stallCnt <= satInc(stallCnt);
        end
    end

    assign stall_cnt = stallCnt;

endmodule
